// File: rtl/simple_if_arbiter.sv
// Round-robin arbiter sharing one simple memory port among NUM_REQ requesters.
// Optional grant locking is compiled in with `define SIMPLE_IF_ARB_LOCK_EN.
module simple_if_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [63:0] MEM_BASE = '0,
  parameter int unsigned MEM_AW   = 12
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0]   wstrb_i,
`ifdef SIMPLE_IF_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock_i,
`endif
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [1:0]                    resp_o,
  output logic                          mem_we_o,
  output logic [MEM_AW-1:0]             mem_waddr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic [DATA_W/8-1:0]           mem_wstrb_o,
  output logic                          mem_re_o,
  output logic [MEM_AW-1:0]             mem_raddr_o,
  input  logic [1:0]                    mem_wresp_i,
  input  logic [1:0]                    mem_rresp_i,
  input  logic [DATA_W-1:0]             mem_rdata_i
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned PtrW  = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StMem, StRsp} state_e;

  state_e              state_q;
  logic [PtrW-1:0]     ptr_q, ptr_d, owner_q;
  logic                we_q, in_win_q;
  logic                mem_we_q, mem_re_q;
  logic [MEM_AW-1:0]   mem_waddr_q, mem_raddr_q;
  logic [DATA_W-1:0]   mem_wdata_q, rdata_q;
  logic [StrbW-1:0]    mem_wstrb_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [1:0]          resp_q;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic [StrbW-1:0]    wstrb_arr [NUM_REQ];

  always_comb begin
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      addr_arr[n]  = addr_i[n*ADDR_W +: ADDR_W];
      wdata_arr[n] = wdata_i[n*DATA_W +: DATA_W];
      wstrb_arr[n] = wstrb_i[n*StrbW +: StrbW];
    end
  end

  // Round-robin search starting at ptr_q.
  logic            win_valid;
  logic [PtrW-1:0] win_idx, cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic grant;
  assign grant = (state_q == StIdle) && win_valid;

  always_comb begin
    gnt_o = '0;
    if (arst_ni && grant) gnt_o[win_idx] = 1'b1;
  end

  // Winner's request fields and memory window decode.
  logic              sel_we, sel_in_win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [StrbW-1:0]  sel_wstrb;
  logic [64:0]       addr_ext, diff;
  logic [MEM_AW-1:0] sel_off;

  always_comb begin
    sel_we     = we_i[win_idx];
    sel_addr   = addr_arr[win_idx];
    sel_wdata  = wdata_arr[win_idx];
    sel_wstrb  = wstrb_arr[win_idx];
    addr_ext   = 65'(sel_addr);
    diff       = addr_ext - {1'b0, MEM_BASE};
    sel_in_win = (addr_ext >= {1'b0, MEM_BASE}) && ((diff >> MEM_AW) == '0);
    sel_off    = diff[MEM_AW-1:0];
  end

  logic [PtrW-1:0] ptr_adv;
  assign ptr_adv = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef SIMPLE_IF_ARB_LOCK_EN
  logic [2:0]      lock_cnt_q, lock_cnt_d;
  logic [PtrW-1:0] lock_own_q;

  // A locked grant holds the pointer, but the fourth in a row to one owner releases it.
  always_comb begin
    ptr_d      = ptr_adv;
    lock_cnt_d = '0;
    if (lock_i[win_idx]) begin
      if ((lock_cnt_q != '0) && (lock_own_q == win_idx)) begin
        lock_cnt_d = lock_cnt_q + 3'd1;
      end else begin
        lock_cnt_d = 3'd1;
      end
      if (lock_cnt_d == 3'd4) begin
        lock_cnt_d = '0;
      end else begin
        ptr_d = ptr_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_cnt_q <= '0;
      lock_own_q <= '0;
    end else if (grant) begin
      lock_cnt_q <= lock_cnt_d;
      lock_own_q <= win_idx;
    end
  end
`else
  always_comb begin
    ptr_d = ptr_adv;
  end
`endif

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      we_q        <= 1'b0;
      in_win_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_raddr_q <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rvalid_q    <= '0;
      resp_q      <= '0;
      rdata_q     <= '0;
    end else begin
      rvalid_q <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q  <= StMem;
            ptr_q    <= ptr_d;
            owner_q  <= win_idx;
            we_q     <= sel_we;
            in_win_q <= sel_in_win;
            // Memory port is loaded only for in-window accesses; otherwise it stays at zero.
            if (sel_in_win && sel_we) begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= sel_off;
              mem_wdata_q <= sel_wdata;
              mem_wstrb_q <= sel_wstrb;
            end
            if (sel_in_win && !sel_we) begin
              mem_re_q    <= 1'b1;
              mem_raddr_q <= sel_off;
            end
          end
        end
        StMem: begin
          state_q     <= StRsp;
          mem_we_q    <= 1'b0;
          mem_re_q    <= 1'b0;
          mem_waddr_q <= '0;
          mem_raddr_q <= '0;
          mem_wdata_q <= '0;
          mem_wstrb_q <= '0;
        end
        StRsp: begin
          state_q           <= StIdle;
          rvalid_q[owner_q] <= 1'b1;
          if (!in_win_q) begin
            resp_q <= 2'b10;
          end else if (we_q) begin
            resp_q <= mem_wresp_i;
          end else begin
            resp_q  <= mem_rresp_i;
            rdata_q <= mem_rdata_i;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rvalid_o    = rvalid_q;
  assign resp_o      = resp_q;
  assign rdata_o     = rdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_re_o    = mem_re_q;
  assign mem_waddr_o = mem_waddr_q;
  assign mem_raddr_o = mem_raddr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;

endmodule

// File: tb/tb_simple_if_arbiter.sv
// Bench for simple_if_arbiter: timeline model checked every cycle plus literal pins.
module tb_simple_if_arbiter;

  localparam int unsigned NR  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned MAW = 12;
  localparam logic [63:0] BASE = 64'h4000_0000;
  localparam logic [31:0] B32  = 32'h4000_0000;

  logic              clk = 1'b0;
  logic              arst_n;
  logic [NR-1:0]     req, we;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wdata;
  logic [NR*SW-1:0]  wstrb;
  logic [NR-1:0]     gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic [1:0]        resp;
  logic              mem_we, mem_re;
  logic [MAW-1:0]    mem_waddr, mem_raddr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic [SW-1:0]     mem_wstrb;
  logic [1:0]        mem_wresp, mem_rresp;
`ifdef SIMPLE_IF_ARB_LOCK_EN
  logic [NR-1:0]     lock;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simple_if_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MEM_BASE(BASE),
    .MEM_AW  (MAW)
  ) dut (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .wstrb_i    (wstrb),
`ifdef SIMPLE_IF_ARB_LOCK_EN
    .lock_i     (lock),
`endif
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .resp_o     (resp),
    .mem_we_o   (mem_we),
    .mem_waddr_o(mem_waddr),
    .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb),
    .mem_re_o   (mem_re),
    .mem_raddr_o(mem_raddr),
    .mem_wresp_i(mem_wresp),
    .mem_rresp_i(mem_rresp),
    .mem_rdata_i(mem_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req[n]           = 1'b1;
    we[n]            = w;
    addr[n*AW +: AW] = a;
    wdata[n*DW +: DW] = d;
    wstrb[n*SW +: SW] = s;
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: a grant at cycle g puts the strobe at g+1, samples memory at g+2,
  // completes at g+3; no new grant while a transaction is outstanding.
  int             cyc = 0;
  int             m_ptr = 0;
  bit             t_valid = 0;
  int             tg, t_req, w;
  bit             t_we, t_in;
  logic [63:0]    t_off, a64;
  logic [DW-1:0]  t_wdata, t_rdata;
  logic [SW-1:0]  t_wstrb;
  logic [1:0]     t_resp;
  int             lk_cnt = 0, lk_own = 0;
  logic [NR-1:0]  e_gnt, e_rv;
  logic [1:0]     e_resp;
  logic [DW-1:0]  e_rdata, e_wdata;
  logic           e_we, e_re;
  logic [MAW-1:0] e_waddr, e_raddr;
  logic [SW-1:0]  e_wstrb;

  initial begin
    forever begin
      @(negedge clk);
      e_gnt = '0; e_rv = '0; e_resp = '0; e_rdata = '0; e_we = 0; e_re = 0;
      e_waddr = '0; e_raddr = '0; e_wdata = '0; e_wstrb = '0;
      if (!arst_n) begin
        t_valid = 0; m_ptr = 0; lk_cnt = 0; lk_own = 0;
      end else begin
        if (t_valid && cyc == tg + 1 && t_in) begin
          if (t_we) begin
            e_we = 1; e_waddr = t_off[MAW-1:0]; e_wdata = t_wdata; e_wstrb = t_wstrb;
          end else begin
            e_re = 1; e_raddr = t_off[MAW-1:0];
          end
        end
        if (t_valid && cyc == tg + 2) begin
          t_resp  = !t_in ? 2'b10 : (t_we ? mem_wresp : mem_rresp);
          t_rdata = (t_in && !t_we) ? mem_rdata : '0;
        end
        if (t_valid && cyc == tg + 3) begin
          e_rv[t_req] = 1'b1; e_resp = t_resp; e_rdata = t_rdata; t_valid = 0;
        end
        if (!t_valid) begin
          w = -1;
          for (int k = 0; k < NR; k++) if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
          if (w >= 0) begin
            e_gnt[w] = 1'b1;
            t_valid = 1; tg = cyc; t_req = w; t_we = we[w];
            a64 = 64'(addr[w*AW +: AW]);
            t_in = (a64 >= BASE) && (a64 < BASE + (64'd1 << MAW));
            t_off = a64 - BASE;
            t_wdata = wdata[w*DW +: DW]; t_wstrb = wstrb[w*SW +: SW];
`ifdef SIMPLE_IF_ARB_LOCK_EN
            if (lock[w]) begin
              lk_cnt = (lk_cnt > 0 && lk_own == w) ? lk_cnt + 1 : 1;
              lk_own = w;
              if (lk_cnt == 4) begin lk_cnt = 0; m_ptr = (w + 1) % NR; end
            end else begin
              lk_cnt = 0; m_ptr = (w + 1) % NR;
            end
`else
            m_ptr = (w + 1) % NR;
`endif
          end
        end
      end
      check("gnt", 64'(gnt), 64'(e_gnt));
      check("rvalid", 64'(rvalid), 64'(e_rv));
      check("mem_we", 64'(mem_we), 64'(e_we));
      check("mem_re", 64'(mem_re), 64'(e_re));
      check("mem_waddr", 64'(mem_waddr), 64'(e_waddr));
      check("mem_raddr", 64'(mem_raddr), 64'(e_raddr));
      check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      check("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
      if (!arst_n || e_rv != '0) begin
        check("resp", 64'(resp), 64'(e_resp));
        check("rdata", 64'(rdata), 64'(e_rdata));
      end
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    arst_n = 0; req = '0; we = '0; addr = '0; wdata = '0; wstrb = '0;
    mem_wresp = 2'b00; mem_rresp = 2'b00; mem_rdata = 32'hA5A5_0001;
`ifdef SIMPLE_IF_ARB_LOCK_EN
    lock = '0;
`endif
    // Single write; request already pending during reset.
    set_req(0, 1'b1, B32 + 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_mem_we", 64'(mem_we), 64'h0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1;
    @(negedge clk);
    check("wr_gnt", 64'(gnt), 64'h1);
    drive(); req = '0;
    @(negedge clk);
    check("wr_mem_we", 64'(mem_we), 64'h1);
    check("wr_waddr", 64'(mem_waddr), 64'h10);
    check("wr_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    check("wr_wstrb", 64'(mem_wstrb), 64'hF);
    @(negedge clk);
    @(negedge clk);
    check("wr_rvalid", 64'(rvalid), 64'h1);
    check("wr_resp", 64'(resp), 64'h0);

    // Both requesters held continuously from reset: 0,1,0,1 three cycles apart.
    drive(); arst_n = 0;
    set_req(0, 1'b0, B32 + 32'h20, 32'h0, 4'h0);
    set_req(1, 1'b0, B32 + 32'hFFC, 32'h0, 4'h0);
    drive(); arst_n = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rr_gnt", 64'(gnt), (i % 6 == 0) ? 64'h1 : ((i % 6 == 3) ? 64'h2 : 64'h0));
    end
    drive(); req = '0;
    repeat (4) drive();

    // Out-of-window read.
    set_req(1, 1'b0, B32 + 32'h1000, 32'h0, 4'h0);
    @(negedge clk);
    check("oow_gnt", 64'(gnt), 64'h2);
    drive(); req = '0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("oow_no_re", 64'(mem_re), 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("oow_rvalid", 64'(rvalid), 64'h2);
    check("oow_resp", 64'(resp), 64'h2);
    check("oow_rdata", 64'(rdata), 64'h0);

    // In-window read with error response.
    drive();
    set_req(0, 1'b0, B32 + 32'h40, 32'h0, 4'h0);
    mem_rresp = 2'b11; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("rd_gnt", 64'(gnt), 64'h1);
    drive(); req = '0;
    @(negedge clk);
    check("rd_mem_re", 64'(mem_re), 64'h1);
    check("rd_raddr", 64'(mem_raddr), 64'h40);
    @(negedge clk);
    @(negedge clk);
    check("rd_rvalid", 64'(rvalid), 64'h1);
    check("rd_resp", 64'(resp), 64'h3);
    check("rd_rdata", 64'(rdata), 64'h1234_5678);
    drive(); mem_rresp = 2'b00; mem_rdata = 32'h0BAD_F00D;

    // Below-base read against top-of-window write.
    set_req(0, 1'b0, B32 - 32'h4, 32'h0, 4'h0);
    set_req(1, 1'b1, B32 + 32'hFFE, 32'h5566_7788, 4'b1100);
    repeat (6) @(posedge clk);
    #1 req = '0;
    repeat (4) drive();

    // One requester held: completion coincides with its own next grant.
    set_req(0, 1'b1, B32 + 32'h100, 32'hCAFE_F00D, 4'b0101);
    mem_wresp = 2'b01;
    repeat (7) @(posedge clk);
    #1 req = '0;
    repeat (4) drive();
    mem_wresp = 2'b00;

    // Reset during MEM drops the write and restarts the pointer.
    set_req(1, 1'b1, B32 + 32'h80, 32'h1111_2222, 4'hF);
    @(negedge clk);
    check("rm_gnt", 64'(gnt), 64'h2);
    drive(); req = '0;
    #1 check("rm_mem_we_pre", 64'(mem_we), 64'h1);
    #1 arst_n = 0;
    #1;
    check("rm_gnt0", 64'(gnt), 64'h0);
    check("rm_rvalid0", 64'(rvalid), 64'h0);
    check("rm_mem_we0", 64'(mem_we), 64'h0);
    check("rm_waddr0", 64'(mem_waddr), 64'h0);
    check("rm_wdata0", 64'(mem_wdata), 64'h0);
    check("rm_wstrb0", 64'(mem_wstrb), 64'h0);
    drive(); arst_n = 1;
    set_req(0, 1'b0, B32 + 32'h30, 32'h0, 4'h0);
    set_req(1, 1'b0, B32 + 32'h34, 32'h0, 4'h0);
    @(negedge clk);
    check("rm_ptr0", 64'(gnt), 64'h1);
    drive(); req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 req[1] = 1'b0;
    repeat (5) drive();

`ifdef SIMPLE_IF_ARB_LOCK_EN
    // Locked requester 0 wins four times before requester 1 is served.
    arst_n = 0;
    set_req(0, 1'b0, B32 + 32'h8, 32'h0, 4'h0);
    set_req(1, 1'b0, B32 + 32'hC, 32'h0, 4'h0);
    lock = 2'b01;
    drive(); arst_n = 1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("lock_gnt", 64'(gnt),
            (i == 12) ? 64'h2 : ((i % 3 == 0) ? 64'h1 : 64'h0));
    end
    drive(); req = '0; lock = '0;
    repeat (4) drive();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
